// File: rtl/ppm_pkg.sv
// Shared types and defaults for the pulse period meter.
// Holds the FSM state encoding and the default period counter width.
package ppm_pkg;

  localparam int unsigned CNT_W_DEFAULT = 16;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } ppm_state_e;

endpackage : ppm_pkg

// File: rtl/pulse_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input followed by a rising-edge detector.
// 'rise' is high for one cycle once the synchronized level goes from low to high.
module pulse_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule : pulse_sync_edge

// File: rtl/pulse_period_meter.sv
// Measures the clk-cycle interval between rising edges of an asynchronous divider pulse
// and regenerates a 50%-duty square wave. Optional min/max tracking with PERIOD_MINMAX_EN.
module pulse_period_meter
  import ppm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_pulse,
  input  logic             clr,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             ovf,
  output logic             sq_out
`ifdef PERIOD_MINMAX_EN
  ,
  output logic [CNT_W-1:0] min_period,
  output logic [CNT_W-1:0] max_period
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic rise;

  pulse_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (div_pulse),
    .rise (rise)
  );

  ppm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             sq_q, sq_d;
  logic             cnt_sat;

`ifdef PERIOD_MINMAX_EN
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;
`endif

  assign cnt_sat = (cnt_q == CNT_MAX);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;
    sq_d     = sq_q;
`ifdef PERIOD_MINMAX_EN
    min_d    = min_q;
    max_d    = max_q;
`endif
    if (clr) begin
      // A same-cycle edge is dropped: clear wins outright.
      state_d  = IDLE;
      cnt_d    = '0;
      period_d = '0;
      ovf_d    = 1'b0;
      sq_d     = 1'b0;
`ifdef PERIOD_MINMAX_EN
      min_d    = '1;
      max_d    = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (rise) begin
            cnt_d   = CNT_ONE;
            state_d = MEASURE;
            sq_d    = ~sq_q;
          end
        end
        MEASURE: begin
          if (rise) begin
            valid_d = 1'b1;
            cnt_d   = CNT_ONE;
            sq_d    = ~sq_q;
            if (cnt_sat) begin
              period_d = CNT_MAX;
              ovf_d    = 1'b1;
            end else begin
              period_d = cnt_q;
`ifdef PERIOD_MINMAX_EN
              if (cnt_q < min_q) min_d = cnt_q;
              if (cnt_q > max_q) max_d = cnt_q;
`endif
            end
          end else if (!cnt_sat) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      sq_q     <= 1'b0;
`ifdef PERIOD_MINMAX_EN
      min_q    <= '1;
      max_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      sq_q     <= sq_d;
`ifdef PERIOD_MINMAX_EN
      min_q    <= min_d;
      max_q    <= max_d;
`endif
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign ovf          = ovf_q;
  assign sq_out       = sq_q;
`ifdef PERIOD_MINMAX_EN
  assign min_period   = min_q;
  assign max_period   = max_q;
`endif

endmodule : pulse_period_meter

// File: tb/tb_pulse_period_meter.sv
// Self-checking bench for pulse_period_meter: a 16-bit and a 4-bit instance share stimulus;
// expected periods come from the driven rise-to-rise gaps, clipped to the counter range.
module tb_pulse_period_meter;
  import ppm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic div_pulse = 1'b0;
  logic clr = 1'b0;

  logic [15:0] period16;
  logic        pv16, ovf16, sq16;
  logic [3:0]  period4;
  logic        pv4, ovf4, sq4;
`ifdef PERIOD_MINMAX_EN
  logic [15:0] min16, max16;
  logic [3:0]  min4, max4;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  int obs16[$];
  int obs4[$];
  int tog16 = 0;
  logic sq16_prev = 1'b0;
  int gaps_q[$];

  always #5 clk = ~clk;

  pulse_period_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .div_pulse(div_pulse), .clr(clr),
    .period(period16), .period_valid(pv16), .ovf(ovf16), .sq_out(sq16)
`ifdef PERIOD_MINMAX_EN
    , .min_period(min16), .max_period(max16)
`endif
  );

  pulse_period_meter #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .div_pulse(div_pulse), .clr(clr),
    .period(period4), .period_valid(pv4), .ovf(ovf4), .sq_out(sq4)
`ifdef PERIOD_MINMAX_EN
    , .min_period(min4), .max_period(max4)
`endif
  );

  // Monitor: record every strobe and count square-wave transitions.
  always @(negedge clk) begin
    if (pv16) obs16.push_back(int'(period16));
    if (pv4)  obs4.push_back(int'(period4));
    if (sq16 !== sq16_prev) tog16++;
    sq16_prev = sq16;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int clip(input int g, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (g > mx) ? mx : g;
  endfunction

  // Rise now (caller sits on a negedge); next rise may start 'gap' cycles later.
  task automatic emit(input int gap);
    div_pulse = 1'b1;
    repeat (gap / 2) @(negedge clk);
    div_pulse = 1'b0;
    repeat (gap - gap / 2) @(negedge clk);
  endtask

  // One rise per gap plus a final rise followed by a quiet tail.
  task automatic run_gaps();
    foreach (gaps_q[i]) emit(gaps_q[i]);
    emit(12);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (8) begin
      @(negedge clk);
      div_pulse = ~div_pulse;
    end
    n_tests++;
    if ({period16, pv16, ovf16, sq16} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got period=%0d valid=%b ovf=%b sq=%b, want all 0", period16, pv16, ovf16, sq16);
    end
    n_tests++;
    if (dut.state_q !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d want IDLE", dut.state_q);
    end
    div_pulse = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_tests++;
    if ({period16, pv16, ovf16, sq16, period4, ovf4, sq4} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_release: got period=%0d ovf=%b sq=%b p4=%0d ovf4=%b sq4=%b, want 0",
               period16, ovf16, sq16, period4, ovf4, sq4);
    end
  endtask

  task automatic test_first_edge();
    int b16;
    b16 = obs16.size();
    emit(12);
    n_tests++;
    if (obs16.size() !== b16) begin
      n_fail++;
      $display("FAIL first_edge_strobe: got %0d strobes want 0", obs16.size() - b16);
    end
    n_tests++;
    if (sq16 !== 1'b1 || period16 !== 16'd0) begin
      n_fail++;
      $display("FAIL first_edge_out: got sq=%b period=%0d want sq=1 period=0", sq16, period16);
    end
    n_tests++;
    if (dut.state_q !== MEASURE) begin
      n_fail++;
      $display("FAIL first_edge_state: got %0d want MEASURE", dut.state_q);
    end
  endtask

  task automatic test_steady();
    int b16, t0, got;
    do_clr();
    b16 = obs16.size();
    t0  = tog16;
    gaps_q = '{20, 20, 20, 20};
    run_gaps();
    got = obs16.size() - b16;
    n_tests++;
    if (got !== 4) begin
      n_fail++;
      $display("FAIL steady_count: got %0d strobes want 4", got);
    end
    for (int i = 0; i < got && i < 4; i++) begin
      n_tests++;
      if (obs16[b16 + i] !== 20) begin
        n_fail++;
        $display("FAIL steady_period[%0d]: got %0d want 20", i, obs16[b16 + i]);
      end
    end
    n_tests++;
    if (tog16 - t0 !== 5 || sq16 !== 1'b1 || ovf16 !== 1'b0) begin
      n_fail++;
      $display("FAIL steady_sq_ovf: got toggles=%0d sq=%b ovf=%b want 5/1/0", tog16 - t0, sq16, ovf16);
    end
  endtask

  task automatic test_overflow();
    int b4, got;
    int exp4[2];
    exp4 = '{15, 10};
    do_clr();
    b4 = obs4.size();
    gaps_q = '{20, 10};
    run_gaps();
    got = obs4.size() - b4;
    n_tests++;
    if (got !== 2) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d strobes want 2", got);
    end
    for (int i = 0; i < got && i < 2; i++) begin
      n_tests++;
      if (obs4[b4 + i] !== exp4[i]) begin
        n_fail++;
        $display("FAIL ovf_period[%0d]: got %0d want %0d", i, obs4[b4 + i], exp4[i]);
      end
    end
    n_tests++;
    if (ovf4 !== 1'b1 || period4 !== 4'd10) begin
      n_fail++;
      $display("FAIL ovf_sticky: got ovf=%b period=%0d want ovf=1 period=10", ovf4, period4);
    end
    n_tests++;
    if (ovf16 !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_wide: got ovf=%b want 0", ovf16);
    end
  endtask

  task automatic test_clear();
    int b16, t0;
    do_clr();
    emit(12);
    emit(12);
    // Third rise: hold clr on the cycle the synchronized edge reaches the FSM.
    div_pulse = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    b16 = obs16.size();
    t0  = tog16;
    @(negedge clk);
    clr = 1'b0;
    div_pulse = 1'b0;
    repeat (8) @(negedge clk);
    n_tests++;
    if (obs16.size() !== b16 || tog16 !== t0) begin
      n_fail++;
      $display("FAIL clr_edge: got strobes=%0d toggles=%0d want 0/0", obs16.size() - b16, tog16 - t0);
    end
    n_tests++;
    if (dut.state_q !== IDLE || sq16 !== 1'b0 || period16 !== 16'd0 || ovf16 !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_state: got state=%0d sq=%b period=%0d ovf=%b want IDLE/0/0/0",
               dut.state_q, sq16, period16, ovf16);
    end
    b16 = obs16.size();
    emit(12);
    n_tests++;
    if (obs16.size() !== b16 || sq16 !== 1'b1 || dut.state_q !== MEASURE) begin
      n_fail++;
      $display("FAIL clr_rearm: got strobes=%0d sq=%b state=%0d want 0/1/MEASURE",
               obs16.size() - b16, sq16, dut.state_q);
    end
    emit(12);
    n_tests++;
    if (obs16.size() !== b16 + 1 || period16 !== 16'd12) begin
      n_fail++;
      $display("FAIL clr_after: got strobes=%0d period=%0d want 1/12", obs16.size() - b16, period16);
    end
  endtask

  task automatic test_random();
    int b16, b4, n, g, got16, got4;
    int exp16[$];
    int exp4[$];
    logic exp_ovf4;
    for (int it = 0; it < 4; it++) begin
      do_clr();
      b16 = obs16.size();
      b4  = obs4.size();
      n = $urandom_range(3, 8);
      gaps_q.delete();
      exp16.delete();
      exp4.delete();
      exp_ovf4 = 1'b0;
      for (int i = 0; i < n - 1; i++) begin
        g = $urandom_range(4, 60);
        if (g == 15) g = 16;
        gaps_q.push_back(g);
        exp16.push_back(clip(g, 16));
        exp4.push_back(clip(g, 4));
        if (g > 15) exp_ovf4 = 1'b1;
      end
      run_gaps();
      got16 = obs16.size() - b16;
      got4  = obs4.size() - b4;
      n_tests++;
      if (got16 !== exp16.size() || got4 !== exp4.size()) begin
        n_fail++;
        $display("FAIL rand_count[%0d]: got %0d/%0d strobes want %0d", it, got16, got4, exp16.size());
      end
      for (int i = 0; i < got16 && i < exp16.size(); i++) begin
        n_tests++;
        if (obs16[b16 + i] !== exp16[i] || (i < got4 && obs4[b4 + i] !== exp4[i])) begin
          n_fail++;
          $display("FAIL rand_period[%0d.%0d]: got %0d/%0d want %0d/%0d",
                   it, i, obs16[b16 + i], (i < got4) ? obs4[b4 + i] : -1, exp16[i], exp4[i]);
        end
      end
      n_tests++;
      if (ovf16 !== 1'b0 || ovf4 !== exp_ovf4 || sq16 !== n[0] || sq4 !== n[0]) begin
        n_fail++;
        $display("FAIL rand_flags[%0d]: got ovf=%b ovf4=%b sq=%b sq4=%b want 0/%b/%b/%b",
                 it, ovf16, ovf4, sq16, sq4, exp_ovf4, n[0], n[0]);
      end
    end
  endtask

`ifdef PERIOD_MINMAX_EN
  task automatic test_minmax();
    do_clr();
    gaps_q = '{10, 30, 20};
    run_gaps();
    n_tests++;
    if (min16 !== 16'd10 || max16 !== 16'd30) begin
      n_fail++;
      $display("FAIL minmax_track: got min=%0d max=%0d want 10/30", min16, max16);
    end
    do_clr();
    n_tests++;
    if (min16 !== 16'hFFFF || max16 !== 16'd0 || min4 !== 4'hF || max4 !== 4'd0) begin
      n_fail++;
      $display("FAIL minmax_clr: got min=%0h max=%0d min4=%0h max4=%0d want ffff/0/f/0",
               min16, max16, min4, max4);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_edge();
    test_steady();
    test_overflow();
    test_clear();
    test_random();
`ifdef PERIOD_MINMAX_EN
    test_minmax();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pulse_period_meter

// File: doc/pulse_period_meter.md
PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, period counter width in bits (minimum 4).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flop count for div_pulse (minimum 2).
REQ-003 SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port div_pulse  input  1  asynchronous carry/terminal-count output of the upstream preset divide counter.
REQ-006 SHALL have port clr  input  1  synchronous clear, active high.
REQ-007 SHALL have port period  output  CNT_W  last measured rising-edge-to-rising-edge interval in clk cycles.
REQ-008 SHALL have port period_valid  output  1  one-cycle strobe when period updates.
REQ-009 SHALL have port ovf  output  1  sticky flag: an interval exceeded 2^CNT_W-1 cycles.
REQ-010 SHALL have port sq_out  output  1  50%-duty square wave; toggles on each detected div_pulse rising edge.

Function
REQ-011 SHALL pass div_pulse through SYNC_STAGES flops, then detect a rising edge (sync high, previous sync low); edge is seen SYNC_STAGES+1 clk edges after the input rise.
REQ-012 SHALL implement FSM states IDLE and MEASURE; reset and clr enter IDLE.
REQ-013 SHALL, in IDLE, hold cnt at 0; on edge: cnt<=1, go MEASURE, toggle sq_out, no period_valid.
REQ-014 SHALL, in MEASURE without edge, increment cnt each cycle, saturating at 2^CNT_W-1.
REQ-015 SHALL, in MEASURE with edge, load period<=cnt, pulse period_valid on the next cycle for exactly one cycle, reload cnt<=1, toggle sq_out, stay in MEASURE.
REQ-016 SHALL, if cnt is saturated when the edge arrives, load period<=2^CNT_W-1 and set ovf; ovf stays set until reset or clr.
REQ-017 SHALL give period = t1-t0, where t0 and t1 are the clk cycles of successive detected edges.
REQ-018 SHALL give clr priority over a same-cycle edge: the edge is discarded, no valid strobe, no sq_out toggle.
REQ-019 SHALL hold period unchanged between updates.
REQ-020 SHALL not guarantee detection of pulses high or low for less than one clk period; minimum measurable interval is 2 cycles.

Reset
REQ-021 SHALL on rst_n low asynchronously clear the sync flops, cnt, period, period_valid, ovf and sq_out to 0 and enter IDLE.
REQ-022 SHALL, on reset mid-MEASURE, discard the partial interval; the first edge after release only re-arms.
REQ-023 SHALL have clr give the same end state as reset, applied synchronously.

Configuration
REQ-024 SHALL, with PERIOD_MINMAX_EN defined, add outputs min_period and max_period (CNT_W each), updated on each non-overflow measurement; reset/clr values are all-ones and 0 respectively.
REQ-025 SHALL, without PERIOD_MINMAX_EN, omit both ports and their logic; all other behaviour is identical.

Structure
REQ-026 SHALL place the FSM state typedef (IDLE, MEASURE) and the default CNT_W constant in shared package ppm_pkg.
REQ-027 SHALL implement the synchronizer and edge detect as sub-module pulse_sync_edge (parameter SYNC_STAGES; ports clk, rst_n, din, rise).

Verification
REQ-028 SHALL check reset: after rst_n low with div_pulse toggling -> period=0, period_valid=0, ovf=0, sq_out=0, FSM in IDLE.
REQ-029 SHALL check steady rate: div_pulse rises every 20 clk, 5 edges -> 4 valid strobes each with period=20, sq_out toggles 5 times, ovf=0.
REQ-030 SHALL check the first edge: a single rise after reset -> no period_valid, sq_out=1.
REQ-031 SHALL check overflow: CNT_W=4, edges 20 cycles apart -> period=15, ovf=1 and still set after a later 10-cycle interval that reports period=10.
REQ-032 SHALL check clearing: clr mid-MEASURE, asserted in the same cycle as an edge -> no strobe, no toggle, IDLE; the next edge re-arms only.
REQ-033 SHALL check PERIOD_MINMAX_EN: intervals 10, 30, 20 -> min_period=10, max_period=30; after clr -> all-ones and 0.
